// File: rtl/axi_multi_ch_ctrl.sv
// axi_multi_ch_ctrl: round-robin burst scheduler for CH_NUM write and CH_NUM read streams
// Each direction shares one AXI master across its channels. Every channel has its own
// address window and circular pointer.
// Ports: ch_{wr,rd}_* carry per-channel windows, lengths, clears and FIFO levels, packed
// with channel 0 in the low bits. axi_{wr,rd}_* handshake with the AXI masters.
// ch_wr_fifo_rd_en and ch_rd_fifo_wr_en steer the external FIFOs.
// Optional: define TAIL_BURST_EN to shorten the last burst so it fills the window exactly.
module axi_multi_ch_ctrl_dir #(
  parameter int CH_NUM     = 2,
  parameter int ADDR_W     = 30,
  parameter int LEN_W      = 8,
  parameter int CNT_W      = 10,
  parameter int BEAT_BYTES = 8,
  parameter int CH_ID_W    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CH_NUM*ADDR_W-1:0] beg_i,
  input  logic [CH_NUM*ADDR_W-1:0] end_i,
  input  logic [CH_NUM*LEN_W-1:0]  len_i,
  input  logic [CH_NUM-1:0]        clr_i,
  input  logic [CH_NUM-1:0]        gate_i,
  input  logic [CH_NUM*CNT_W-1:0]  cnt_i,
  input  logic                     ready_i,
  input  logic                     active_i,
  input  logic                     done_i,
  output logic                     start_o,
  output logic [ADDR_W-1:0]        addr_o,
  output logic [LEN_W-1:0]         len_o,
  output logic [CH_ID_W-1:0]       ch_o,
  output logic [CH_NUM-1:0]        fifo_en_o
);
  localparam int SH = $clog2(BEAT_BYTES);
  localparam int SW = ADDR_W + 2;
  typedef enum logic [1:0] {IDLE, REQ, BUSY} state_t;
  state_t             state_q;
  logic [ADDR_W-1:0]  ptr_q [CH_NUM];
  logic [ADDR_W-1:0]  beg_a [CH_NUM];
  logic [ADDR_W-1:0]  end_a [CH_NUM];
  logic [LEN_W-1:0]   len_a [CH_NUM];
  logic [LEN_W-1:0]   eff_len [CH_NUM];
  logic [CH_NUM-1:0]  elig;
  logic [CH_ID_W-1:0] rr_q, gnt;
  logic               any_elig;
  logic [ADDR_W-1:0]  issued, ptr_d;
  logic [SW-1:0]      nxt, lim;
  always_comb begin
    for (int i = 0; i < CH_NUM; i++) begin
      beg_a[i] = beg_i[i*ADDR_W +: ADDR_W];
      end_a[i] = end_i[i*ADDR_W +: ADDR_W];
      len_a[i] = len_i[i*LEN_W +: LEN_W];
`ifdef TAIL_BURST_EN
      // a full burst would run past the window end: shrink it to the remaining tail
      eff_len[i] = ((SW'(ptr_q[i]) + ((SW'(len_a[i]) + 1'b1) << SH) - 1'b1) > SW'(end_a[i]))
                 ? LEN_W'(((end_a[i] - ptr_q[i] + 1'b1) >> SH) - 1'b1) : len_a[i];
`else
      eff_len[i] = len_a[i];
`endif
      elig[i] = gate_i[i] && (32'(cnt_i[i*CNT_W +: CNT_W]) >= 32'(eff_len[i]) + 32'd1);
    end
    any_elig = |elig;
    // scan downwards so the first eligible channel at or after rr_q wins
    gnt = '0;
    for (int k = CH_NUM - 1; k >= 0; k--)
      if (elig[(int'(rr_q) + k) % CH_NUM]) gnt = CH_ID_W'((int'(rr_q) + k) % CH_NUM);
    issued = ADDR_W'((SW'(len_o) + 1'b1) << SH);
    nxt = SW'(ptr_q[ch_o]) + SW'(issued);
`ifdef TAIL_BURST_EN
    lim = nxt;
`else
    // wrap early if the following full burst would not fit; extra width catches overflow
    lim = nxt + SW'(issued) - 1'b1;
`endif
    ptr_d = (lim > SW'(end_a[ch_o])) ? beg_a[ch_o] : ADDR_W'(nxt);
    for (int i = 0; i < CH_NUM; i++)
      fifo_en_o[i] = active_i && (state_q == BUSY) && (ch_o == CH_ID_W'(i));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      start_o <= 1'b0;
      addr_o  <= '0;
      len_o   <= '0;
      ch_o    <= '0;
      for (int i = 0; i < CH_NUM; i++) ptr_q[i] <= beg_a[i];
    end else begin
      case (state_q)
        IDLE: if (any_elig && ready_i) begin
          addr_o  <= ptr_q[gnt];
          len_o   <= eff_len[gnt];
          ch_o    <= gnt;
          start_o <= 1'b1;
          rr_q    <= CH_ID_W'((int'(gnt) + 1) % CH_NUM);
          state_q <= REQ;
        end
        REQ: if (!ready_i) begin
          start_o <= 1'b0;
          state_q <= BUSY;
        end
        BUSY: if (done_i) begin
          ptr_q[ch_o] <= ptr_d;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      // clear overrides a same-cycle done update; the burst in flight still completes
      for (int i = 0; i < CH_NUM; i++) if (clr_i[i]) ptr_q[i] <= beg_a[i];
    end
  end
endmodule

module axi_multi_ch_ctrl #(
  parameter int CH_NUM     = 2,
  parameter int ADDR_W     = 30,
  parameter int LEN_W      = 8,
  parameter int CNT_W      = 10,
  parameter int BEAT_BYTES = 8,
  parameter int CH_ID_W    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CH_NUM*ADDR_W-1:0] ch_wr_beg_addr,
  input  logic [CH_NUM*ADDR_W-1:0] ch_wr_end_addr,
  input  logic [CH_NUM*ADDR_W-1:0] ch_rd_beg_addr,
  input  logic [CH_NUM*ADDR_W-1:0] ch_rd_end_addr,
  input  logic [CH_NUM*LEN_W-1:0]  ch_wr_burst_len,
  input  logic [CH_NUM*LEN_W-1:0]  ch_rd_burst_len,
  input  logic [CH_NUM-1:0]        ch_wr_clr,
  input  logic [CH_NUM-1:0]        ch_rd_clr,
  input  logic [CH_NUM-1:0]        ch_rd_enable,
  input  logic [CH_NUM*CNT_W-1:0]  ch_wr_fifo_cnt,
  input  logic [CH_NUM*CNT_W-1:0]  ch_rd_fifo_space,
  input  logic                     axi_wr_ready,
  input  logic                     axi_writing,
  input  logic                     axi_wr_done,
  output logic                     axi_wr_start,
  output logic [ADDR_W-1:0]        axi_wr_addr,
  output logic [LEN_W-1:0]         axi_wr_len,
  output logic [CH_ID_W-1:0]       axi_wr_ch,
  output logic [CH_NUM-1:0]        ch_wr_fifo_rd_en,
  input  logic                     axi_rd_ready,
  input  logic                     axi_reading,
  input  logic                     axi_rd_done,
  output logic                     axi_rd_start,
  output logic [ADDR_W-1:0]        axi_rd_addr,
  output logic [LEN_W-1:0]         axi_rd_len,
  output logic [CH_ID_W-1:0]       axi_rd_ch,
  output logic [CH_NUM-1:0]        ch_rd_fifo_wr_en
);
  axi_multi_ch_ctrl_dir #(
    .CH_NUM(CH_NUM), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .CNT_W(CNT_W),
    .BEAT_BYTES(BEAT_BYTES), .CH_ID_W(CH_ID_W)
  ) u_wr (
    .clk(clk), .rst(rst), .beg_i(ch_wr_beg_addr), .end_i(ch_wr_end_addr),
    .len_i(ch_wr_burst_len), .clr_i(ch_wr_clr), .gate_i({CH_NUM{1'b1}}),
    .cnt_i(ch_wr_fifo_cnt), .ready_i(axi_wr_ready), .active_i(axi_writing),
    .done_i(axi_wr_done), .start_o(axi_wr_start), .addr_o(axi_wr_addr),
    .len_o(axi_wr_len), .ch_o(axi_wr_ch), .fifo_en_o(ch_wr_fifo_rd_en)
  );
  axi_multi_ch_ctrl_dir #(
    .CH_NUM(CH_NUM), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .CNT_W(CNT_W),
    .BEAT_BYTES(BEAT_BYTES), .CH_ID_W(CH_ID_W)
  ) u_rd (
    .clk(clk), .rst(rst), .beg_i(ch_rd_beg_addr), .end_i(ch_rd_end_addr),
    .len_i(ch_rd_burst_len), .clr_i(ch_rd_clr), .gate_i(ch_rd_enable),
    .cnt_i(ch_rd_fifo_space), .ready_i(axi_rd_ready), .active_i(axi_reading),
    .done_i(axi_rd_done), .start_o(axi_rd_start), .addr_o(axi_rd_addr),
    .len_o(axi_rd_len), .ch_o(axi_rd_ch), .fifo_en_o(ch_rd_fifo_wr_en)
  );
endmodule

// File: tb/tb_axi_multi_ch_ctrl.sv
// tb_axi_multi_ch_ctrl: scoreboard bench for axi_multi_ch_ctrl with directed bursts
module tb_axi_multi_ch_ctrl;
  localparam int CH_NUM = 2, ADDR_W = 30, LEN_W = 8, CNT_W = 10, CH_ID_W = 1;
  typedef struct packed {logic [ADDR_W-1:0] addr; logic [LEN_W-1:0] len; logic ch;} exp_t;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [ADDR_W-1:0] wr_beg [CH_NUM], wr_end [CH_NUM], rd_beg [CH_NUM], rd_end [CH_NUM];
  logic [LEN_W-1:0]  wr_len [CH_NUM], rd_len [CH_NUM];
  logic [CNT_W-1:0]  wr_cnt [CH_NUM], rd_space [CH_NUM];
  logic [CH_NUM-1:0] wr_clr = 0, rd_clr = 0, rd_enable = 0;
  logic axi_wr_ready = 1, axi_writing = 0, axi_wr_done = 0;
  logic axi_rd_ready = 1, axi_reading = 0, axi_rd_done = 0;
  logic axi_wr_start, axi_rd_start;
  logic [ADDR_W-1:0] axi_wr_addr, axi_rd_addr;
  logic [LEN_W-1:0] axi_wr_len, axi_rd_len;
  logic [CH_ID_W-1:0] axi_wr_ch, axi_rd_ch;
  logic [CH_NUM-1:0] ch_wr_fifo_rd_en, ch_rd_fifo_wr_en;
  axi_multi_ch_ctrl dut (
    .clk(clk), .rst(rst),
    .ch_wr_beg_addr({wr_beg[1], wr_beg[0]}), .ch_wr_end_addr({wr_end[1], wr_end[0]}),
    .ch_rd_beg_addr({rd_beg[1], rd_beg[0]}), .ch_rd_end_addr({rd_end[1], rd_end[0]}),
    .ch_wr_burst_len({wr_len[1], wr_len[0]}), .ch_rd_burst_len({rd_len[1], rd_len[0]}),
    .ch_wr_clr(wr_clr), .ch_rd_clr(rd_clr), .ch_rd_enable(rd_enable),
    .ch_wr_fifo_cnt({wr_cnt[1], wr_cnt[0]}), .ch_rd_fifo_space({rd_space[1], rd_space[0]}),
    .axi_wr_ready(axi_wr_ready), .axi_writing(axi_writing), .axi_wr_done(axi_wr_done),
    .axi_wr_start(axi_wr_start), .axi_wr_addr(axi_wr_addr), .axi_wr_len(axi_wr_len),
    .axi_wr_ch(axi_wr_ch), .ch_wr_fifo_rd_en(ch_wr_fifo_rd_en),
    .axi_rd_ready(axi_rd_ready), .axi_reading(axi_reading), .axi_rd_done(axi_rd_done),
    .axi_rd_start(axi_rd_start), .axi_rd_addr(axi_rd_addr), .axi_rd_len(axi_rd_len),
    .axi_rd_ch(axi_rd_ch), .ch_rd_fifo_wr_en(ch_rd_fifo_wr_en)
  );
  int n_chk = 0, n_pass = 0;
  exp_t wq[$], rq[$];
  logic wr_prev = 0, rd_prev = 0, wr_live = 0, rd_live = 0, wr_cur = 0, rd_cur = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask
  function automatic exp_t mk(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l, input logic c);
    return '{addr: a, len: l, ch: c};
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (axi_wr_start && !wr_prev) begin
        if (wq.size() == 0) begin
          n_chk++;
          $display("FAIL wr_unexpected_start: got addr %0h expected no start", axi_wr_addr);
        end else begin
          e = wq.pop_front();
          chk("wr_addr", 32'(axi_wr_addr), 32'(e.addr));
          chk("wr_len", 32'(axi_wr_len), 32'(e.len));
          chk("wr_ch", 32'(axi_wr_ch), 32'(e.ch));
          wr_cur = e.ch;
        end
      end
      if (axi_rd_start && !rd_prev) begin
        if (rq.size() == 0) begin
          n_chk++;
          $display("FAIL rd_unexpected_start: got addr %0h expected no start", axi_rd_addr);
        end else begin
          e = rq.pop_front();
          chk("rd_addr", 32'(axi_rd_addr), 32'(e.addr));
          chk("rd_len", 32'(axi_rd_len), 32'(e.len));
          chk("rd_ch", 32'(axi_rd_ch), 32'(e.ch));
          rd_cur = e.ch;
        end
      end
      if (axi_writing) chk("wr_fifo_en", 32'(ch_wr_fifo_rd_en), wr_live ? 32'(1) << wr_cur : 32'd0);
      if (axi_reading) chk("rd_fifo_en", 32'(ch_rd_fifo_wr_en), rd_live ? 32'(1) << rd_cur : 32'd0);
    end
    wr_prev = axi_wr_start;
    rd_prev = axi_rd_start;
  end
  task automatic wait_start(input bit rd, output bit ok);
    int t = 0;
    while (!(rd ? axi_rd_start : axi_wr_start) && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    ok = (t < 40);
    if (!ok) begin
      n_chk++;
      $display("FAIL %s_start_timeout: got no start expected start within 40 cycles", rd ? "rd" : "wr");
    end
  endtask
  // AXI master model: accept the request, stream two beats of data phase, pulse done
  task automatic xfer(input bit rd, input logic [CH_NUM-1:0] clr);
    bit ok;
    wait_start(rd, ok);
    if (!ok) return;
    if (rd) axi_rd_ready = 0; else axi_wr_ready = 0;
    @(posedge clk); #1;
    chk(rd ? "rd_start_drop" : "wr_start_drop", 32'(rd ? axi_rd_start : axi_wr_start), 0);
    if (rd) begin axi_reading = 1; rd_live = 1; end
    else begin axi_writing = 1; wr_live = 1; end
    repeat (2) @(posedge clk);
    #1;
    if (rd) begin
      axi_reading = 0; rd_live = 0; axi_rd_done = 1; axi_rd_ready = 1; rd_clr = clr;
    end else begin
      axi_writing = 0; wr_live = 0; axi_wr_done = 1; axi_wr_ready = 1; wr_clr = clr;
    end
    @(posedge clk); #1;
    axi_wr_done = 0; axi_rd_done = 0; wr_clr = 0; rd_clr = 0;
  endtask
  task automatic do_reset();
    rst = 1;
    wr_live = 0; rd_live = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1);
  end
  initial begin
    bit ok;
    wr_beg[0] = 'h0;    wr_end[0] = 'h3FF;  wr_len[0] = 15;
    wr_beg[1] = 'h1000; wr_end[1] = 'h13FF; wr_len[1] = 7;
    rd_beg[0] = 'h2000; rd_end[0] = 'h23FF; rd_len[0] = 15;
    rd_beg[1] = 'h3000; rd_end[1] = 'h33FF; rd_len[1] = 15;
    wr_cnt[0] = 0; wr_cnt[1] = 0; rd_space[0] = 0; rd_space[1] = 0;
    do_reset();
    chk("rst_wr_start", 32'(axi_wr_start), 0);
    chk("rst_wr_addr", 32'(axi_wr_addr), 0);
    chk("rst_wr_len", 32'(axi_wr_len), 0);
    chk("rst_wr_ch", 32'(axi_wr_ch), 0);
    chk("rst_wr_en", 32'(ch_wr_fifo_rd_en), 0);
    chk("rst_rd_start", 32'(axi_rd_start), 0);
    chk("rst_rd_addr", 32'(axi_rd_addr), 0);
    chk("rst_rd_en", 32'(ch_rd_fifo_wr_en), 0);
    // single channel: eight 128-byte bursts cover the 1 KiB window, ninth wraps
    for (int k = 0; k < 9; k++) begin
      wq.push_back(mk(ADDR_W'((k % 8) * 'h80), 15, 0));
      if (k == 0) begin
        wr_cnt[0] = 16;
        @(posedge clk); #1;
        chk("wr_latency", 32'(axi_wr_start), 1);
      end
      xfer(0, 0);
    end
    wr_cnt[0] = 0;
    // round robin across both write channels; ch1 has exactly its 8 beats
    do_reset();
    wq.push_back(mk('h0, 15, 0));
    wq.push_back(mk('h1000, 7, 1));
    wq.push_back(mk('h80, 15, 0));
    wq.push_back(mk('h1040, 7, 1));
    wr_cnt[0] = 16; wr_cnt[1] = 8;
    repeat (4) xfer(0, 0);
    wr_cnt[0] = 0; wr_cnt[1] = 0;
    // read gating by enable and by free space
    do_reset();
    rd_space[0] = 512; rd_space[1] = 512;
    repeat (5) @(posedge clk);
    #1;
    chk("rd_gated_by_enable", 32'(axi_rd_start), 0);
    rq.push_back(mk('h2000, 15, 0));
    rd_enable[0] = 1;
    @(posedge clk); #1;
    chk("rd_latency", 32'(axi_rd_start), 1);
    rd_enable[0] = 0;
    xfer(1, 0);
    rd_space[0] = 15;
    rd_enable[0] = 1;
    repeat (5) @(posedge clk);
    #1;
    chk("rd_gated_by_space", 32'(axi_rd_start), 0);
    rq.push_back(mk('h2080, 15, 0));
    rd_space[0] = 16;
    xfer(1, 0);
    rd_enable[0] = 0;
    // clear collides with done while ptr was 0x100
    do_reset();
    wq.push_back(mk('h0, 15, 0));
    wq.push_back(mk('h80, 15, 0));
    wq.push_back(mk('h100, 15, 0));
    wq.push_back(mk('h0, 15, 0));
    wr_cnt[0] = 16;
    xfer(0, 0);
    xfer(0, 0);
    xfer(0, 2'b01);
    xfer(0, 0);
    wr_cnt[0] = 0;
    // reset while BUSY, then a stale done must not move the pointer
    do_reset();
    wq.push_back(mk('h0, 15, 0));
    wr_cnt[0] = 16;
    wait_start(0, ok);
    axi_wr_ready = 0;
    @(posedge clk); #1;
    axi_writing = 1; wr_live = 1; wr_cnt[0] = 0;
    @(posedge clk); #1;
    rst = 1; wr_live = 0;
    @(posedge clk); #1;
    rst = 0;
    chk("mid_rst_start", 32'(axi_wr_start), 0);
    chk("mid_rst_addr", 32'(axi_wr_addr), 0);
    chk("mid_rst_len", 32'(axi_wr_len), 0);
    chk("mid_rst_en", 32'(ch_wr_fifo_rd_en), 0);
    @(posedge clk); #1;
    axi_writing = 0; axi_wr_done = 1;
    @(posedge clk); #1;
    axi_wr_done = 0; axi_wr_ready = 1;
    wq.push_back(mk('h0, 15, 0));
    wr_cnt[0] = 16;
    xfer(0, 0);
    wr_cnt[0] = 0;
    // 256-byte bursts in a 768-byte window, then in a 640-byte window
    wr_end[0] = 'h2FF; wr_len[0] = 31;
    do_reset();
    wq.push_back(mk('h0, 31, 0));
    wq.push_back(mk('h100, 31, 0));
    wq.push_back(mk('h200, 31, 0));
    wq.push_back(mk('h0, 31, 0));
    wr_cnt[0] = 32;
    repeat (4) xfer(0, 0);
    wr_cnt[0] = 0;
    wr_end[0] = 'h27F;
    do_reset();
    wq.push_back(mk('h0, 31, 0));
    wq.push_back(mk('h100, 31, 0));
`ifdef TAIL_BURST_EN
    wq.push_back(mk('h200, 15, 0));
`endif
    wq.push_back(mk('h0, 31, 0));
    wr_cnt[0] = 32;
`ifdef TAIL_BURST_EN
    repeat (4) xfer(0, 0);
`else
    repeat (3) xfer(0, 0);
`endif
    wr_cnt[0] = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("wr_queue_drained", wq.size(), 0);
    chk("rd_queue_drained", rq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
